pc_sequencer: RTL

- Control FSM that drives the program counter's step and jump controls: next_flag, absjump_en and target.
- Consumes per-instruction control info from the decoder and stalls the PC during multi-cycle memory operations.
- Holds a small return-address stack so CALL and RET work.
- Sits between the decoder and the PC, and owns start, halt and error reporting for the core.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_sequencer_ret_stack.sv | 69 ++++++
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: decoded operation classes and FSM states.
// The decoder and the testbench import this package too, so the encodings
// here are the single source of truth.
package pc_seq_pkg;

  // Decoded operation class delivered by the decoder alongside instr_valid.
  // Code 7 is reserved and the sequencer treats it as a plain sequential step.
  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_MEM    = 3'd5,
    OP_HALT   = 3'd6,
    OP_RSVD   = 3'd7
  } op_kind_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALTED   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack for CALL/RET. The pointer counts entries (0..DEPTH),
// so full and empty are unambiguous. Entry storage is never reset; the top
// entry is only meaningful when the stack is not empty. DEPTH must be a power
// of two and at least 2 so the entry index wraps cleanly.
module ret_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [D-1:0] data_i,
  output logic [D-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] FULL_CNT = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

  logic [D-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_d;
  logic [IW-1:0]  wrIdx;
  logic [IW-1:0]  topIdx;

  // Write slot is the pointer's low bits; the top entry sits one below it
  // (with sp = DEPTH the low bits wrap to 0, so the top is DEPTH-1).
  assign wrIdx   = sp_q[IW-1:0];
  assign topIdx  = wrIdx - IDX_ONE;
  assign full_o  = (sp_q == FULL_CNT);
  assign empty_o = (sp_q == '0);
  assign data_o  = mem_q[topIdx];

  // Pointer next-state: clear wins, then push, then pop; overflowing or
  // underflowing requests leave the pointer untouched.
  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + SP_ONE;
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_ONE;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage: written on an accepted push only, never reset.
  always_ff @(posedge clk) begin
    if (reset && push_i && !clear_i && !full_o) begin
      mem_q[wrIdx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: turns decoded per-instruction control into PC step/jump
// commands, stalls across memory operations, keeps a return-address stack
// for CALL/RET and reports halt and stack errors through sticky flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         instr_valid,
  input  logic [2:0]   op_kind,
  input  logic         cond,
  input  logic [D-1:0] jump_target,
  input  logic [D-1:0] pc_cur,
  input  logic         mem_done,
  output logic         next_flag,
  output logic         absjump_en,
  output logic [D-1:0] target,
  output logic         mem_req,
  output logic         busy,
  output logic         done,
  output logic         stack_err
);

  localparam logic [D-1:0] PC_ONE = D'(1);

  seq_state_t   state_q;
  seq_state_t   state_d;
  op_kind_t     opKind;
  logic         done_q;
  logic         err_q;
  logic         pushEn;
  logic         popEn;
  logic         stackClr;
  logic         setDone;
  logic         setErr;
  logic         stackFull;
  logic         stackEmpty;
  logic [D-1:0] stackTop;
  logic [D-1:0] retAddr;

  assign opKind  = op_kind_t'(op_kind);
  assign retAddr = pc_cur + PC_ONE;

  ret_stack #(
    .D     (D),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .clear_i (stackClr),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  (retAddr),
    .data_o  (stackTop),
    .full_o  (stackFull),
    .empty_o (stackEmpty)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stack faults and HALT park the core in HALTED, MEM
  // stalls until a completion pulse seen while already waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          case (opKind)
            OP_CALL: if (stackFull)  state_d = S_HALTED;
            OP_RET:  if (stackEmpty) state_d = S_HALTED;
            OP_MEM:  state_d = S_MEM_WAIT;
            OP_HALT: state_d = S_HALTED;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_WAIT: begin
        if (mem_done) state_d = S_FETCH;
      end
      S_HALTED: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: PC controls, stack push/pop and flag-update strobes, all
  // forced quiet while reset is held. target is zero unless a load is asked.
  always_comb begin
    next_flag  = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    mem_req    = 1'b0;
    busy       = 1'b0;
    pushEn     = 1'b0;
    popEn      = 1'b0;
    stackClr   = 1'b0;
    setDone    = 1'b0;
    setErr     = 1'b0;
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          stackClr = start;
        end
        S_FETCH: begin
          busy = 1'b1;
          if (instr_valid) begin
            case (opKind)
              OP_JUMP: begin
                next_flag  = 1'b1;
                absjump_en = 1'b1;
                target     = jump_target;
              end
              OP_BRANCH: begin
                next_flag = 1'b1;
                if (cond) begin
                  absjump_en = 1'b1;
                  target     = jump_target;
                end
              end
              OP_CALL: begin
                if (stackFull) begin
                  setErr = 1'b1;
                end else begin
                  pushEn     = 1'b1;
                  next_flag  = 1'b1;
                  absjump_en = 1'b1;
                  target     = jump_target;
                end
              end
              OP_RET: begin
                if (stackEmpty) begin
                  setErr = 1'b1;
                end else begin
                  popEn      = 1'b1;
                  next_flag  = 1'b1;
                  absjump_en = 1'b1;
                  target     = stackTop;
                end
              end
              OP_MEM: begin
                mem_req = 1'b1;
              end
              OP_HALT: begin
                setDone = 1'b1;
              end
              default: begin
                next_flag = 1'b1;
              end
            endcase
          end
        end
        S_MEM_WAIT: begin
          busy      = 1'b1;
          mem_req   = 1'b1;
          next_flag = mem_done;
        end
        S_HALTED: begin
          stackClr = start;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  // Sticky done / stack_err flags: cleared by reset or by a restart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (stackClr) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (setDone) done_q <= 1'b1;
      if (setErr)  err_q  <= 1'b1;
    end
  end

  assign done      = done_q;
  assign stack_err = err_q;

endmodule
